// File: rtl/alarm_ctrl_fsm_if.sv
// Alarm clock controller bundle: keypad/button inputs and
// display/strobe outputs between the controller and its datapath.
interface alarm_ctrl_fsm_if;
  logic       one_second;
  logic       alarm_button;
  logic       time_button;
  logic [3:0] key;
  logic       show_new_time;
  logic       show_a;
  logic       shift;
  logic       load_new_a;
  logic       load_new_c;
  logic       reset_count;

  modport master (
    output one_second, alarm_button, time_button, key,
    input  show_new_time, show_a, shift,
    input  load_new_a, load_new_c, reset_count
  );

  modport slave (
    input  one_second, alarm_button, time_button, key,
    output show_new_time, show_a, shift,
    output load_new_a, load_new_c, reset_count
  );
endinterface

// File: rtl/alarm_ctrl_fsm.sv
// Alarm clock key-entry controller: Moore FSM with a
// saturating inactivity counter that abandons stale key entry.
module alarm_ctrl_fsm #(
  parameter int         TIMEOUT = 10,
  parameter logic [3:0] NOKEY   = 4'd10
) (
  input logic             clock,
  input logic             reset,
  alarm_ctrl_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    SHOW_TIME,
    KEY_STORED,
    KEY_WAITED,
    KEY_ENTRY,
    SHOW_ALARM,
    SET_ALARM_TIME,
    SET_CURRENT_TIME
  } state_e;

  localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       key_hit;
  logic       timeout;
  logic       counting;

  assign key_hit  = (bus.key != NOKEY);
  assign timeout  = bus.one_second && (cnt_q == CNT_LAST);
  assign counting = (state_q == KEY_WAITED) ||
                    (state_q == KEY_ENTRY);

  // State and inactivity counter registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= SHOW_TIME;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state decode; in KEY_ENTRY a key press outranks timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SHOW_TIME: begin
        if (bus.alarm_button) state_d = SHOW_ALARM;
        else if (key_hit)     state_d = KEY_STORED;
      end
      KEY_STORED: state_d = KEY_WAITED;
      KEY_WAITED: begin
        if (!key_hit)     state_d = KEY_ENTRY;
        else if (timeout) state_d = SHOW_TIME;
      end
      KEY_ENTRY: begin
        if (bus.alarm_button)     state_d = SET_ALARM_TIME;
        else if (bus.time_button) state_d = SET_CURRENT_TIME;
        else if (key_hit)         state_d = KEY_STORED;
        else if (timeout)         state_d = SHOW_TIME;
      end
      SHOW_ALARM: begin
        if (!bus.alarm_button) state_d = SHOW_TIME;
      end
      SET_ALARM_TIME:   state_d = SHOW_TIME;
      SET_CURRENT_TIME: state_d = SHOW_TIME;
      default:          state_d = SHOW_TIME;
    endcase
  end

  // Counter restarts on any transition and saturates at 15
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (counting && bus.one_second &&
                 cnt_q != 4'hF) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Moore outputs decoded from the state register alone
  always_comb begin
    bus.show_new_time = 1'b0;
    bus.show_a        = 1'b0;
    bus.shift         = 1'b0;
    bus.load_new_a    = 1'b0;
    bus.load_new_c    = 1'b0;
    bus.reset_count   = 1'b0;
    unique case (state_q)
      KEY_STORED: begin
        bus.show_new_time = 1'b1;
        bus.shift         = 1'b1;
      end
      KEY_WAITED: bus.show_new_time = 1'b1;
      KEY_ENTRY:  bus.show_new_time = 1'b1;
      SHOW_ALARM: bus.show_a = 1'b1;
      SET_ALARM_TIME: begin
        bus.show_new_time = 1'b1;
        bus.load_new_a    = 1'b1;
      end
      SET_CURRENT_TIME: begin
        bus.show_new_time = 1'b1;
        bus.load_new_c    = 1'b1;
        bus.reset_count   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alarm_ctrl_fsm.sv
// Directed bench for alarm_ctrl_fsm: per-scenario stimulus
// tables with hand-derived output vectors after each edge.
module tb_alarm_ctrl_fsm;

  localparam logic [3:0] NK = 4'd10;
  // {show_new_time, show_a, shift, load_new_a, load_new_c, reset_count}
  localparam logic [5:0] O_IDLE  = 6'b000000;
  localparam logic [5:0] O_ST    = 6'b101000;
  localparam logic [5:0] O_NEW   = 6'b100000;
  localparam logic [5:0] O_ALARM = 6'b010000;
  localparam logic [5:0] O_SETA  = 6'b100100;
  localparam logic [5:0] O_SETC  = 6'b100011;

  typedef struct packed {
    logic       a;
    logic       t;
    logic       s;
    logic [3:0] k;
    logic [5:0] e;
  } step_t;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_pass;

  alarm_ctrl_fsm_if bus ();

  alarm_ctrl_fsm #(.TIMEOUT(10), .NOKEY(4'd10)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [5:0] outs();
    return {bus.show_new_time, bus.show_a, bus.shift,
            bus.load_new_a, bus.load_new_c, bus.reset_count};
  endfunction

  function automatic step_t st(input logic a, input logic t,
                               input logic s, input logic [3:0] k,
                               input logic [5:0] e);
    step_t r;
    r.a = a; r.t = t; r.s = s; r.k = k; r.e = e;
    return r;
  endfunction

  task automatic drive(input step_t x);
    bus.alarm_button = x.a;
    bus.time_button  = x.t;
    bus.one_second   = x.s;
    bus.key          = x.k;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.alarm_button = 1'b1;
    bus.time_button  = 1'b1;
    bus.one_second   = 1'b1;
    bus.key          = 4'd3;
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if (outs() !== O_IDLE)
      $display("FAIL reset_hold: got %b expected %b", outs(), O_IDLE);
    else n_pass++;
    bus.alarm_button = 1'b0;
    bus.time_button  = 1'b0;
    bus.one_second   = 1'b0;
    bus.key          = NK;
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(st(0, 0, 0, NK, O_IDLE));
      n_checks++;
      if (outs() !== O_IDLE)
        $display("FAIL reset_idle[%0d]: got %b expected %b",
                 i, outs(), O_IDLE);
      else n_pass++;
    end
  endtask

  task automatic test_key_hold();
    step_t q[$];
    int    nshift = 0;
    q.push_back(st(0, 0, 0, 4'd3, O_ST));
    for (int i = 0; i < 4; i++) q.push_back(st(0, 0, 0, 4'd3, O_NEW));
    q.push_back(st(0, 0, 0, NK, O_NEW));
    q.push_back(st(1, 0, 0, NK, O_SETA));
    q.push_back(st(0, 0, 0, NK, O_IDLE));
    foreach (q[i]) begin
      drive(q[i]);
      nshift += int'(outs()[3]);
      n_checks++;
      if (outs() !== q[i].e)
        $display("FAIL key_hold[%0d]: got %b expected %b",
                 i, outs(), q[i].e);
      else n_pass++;
    end
    n_checks++;
    if (nshift !== 1)
      $display("FAIL key_hold_shifts: got %0d expected 1", nshift);
    else n_pass++;
  endtask

  task automatic test_entry();
    step_t q[$];
    int    nshift = 0;
    int    nloadc = 0;
    for (int d = 1; d <= 4; d++) begin
      q.push_back(st(0, 0, 0, 4'(d), O_ST));
      q.push_back(st(0, 0, 0, NK, O_NEW));
      q.push_back(st(0, 0, 0, NK, O_NEW));
    end
    q.push_back(st(0, 1, 0, NK, O_SETC));
    q.push_back(st(0, 0, 0, NK, O_IDLE));
    foreach (q[i]) begin
      drive(q[i]);
      nshift += int'(outs()[3]);
      nloadc += int'(outs()[1]);
      n_checks++;
      if (outs() !== q[i].e)
        $display("FAIL entry[%0d]: got %b expected %b",
                 i, outs(), q[i].e);
      else n_pass++;
    end
    n_checks++;
    if (nshift !== 4 || nloadc !== 1)
      $display("FAIL entry_counts: got shift=%0d loadc=%0d expected 4/1",
               nshift, nloadc);
    else n_pass++;
  endtask

  task automatic test_timeout();
    step_t q[$];
    q.push_back(st(0, 0, 0, 4'd5, O_ST));
    q.push_back(st(0, 0, 0, NK, O_NEW));
    q.push_back(st(0, 0, 0, NK, O_NEW));
    for (int i = 0; i < 9; i++) begin
      q.push_back(st(0, 0, 1, NK, O_NEW));
      q.push_back(st(0, 0, 0, NK, O_NEW));
    end
    q.push_back(st(0, 0, 1, NK, O_IDLE));
    q.push_back(st(0, 0, 0, NK, O_IDLE));
    q.push_back(st(0, 0, 0, 4'd5, O_ST));
    q.push_back(st(0, 0, 0, NK, O_NEW));
    q.push_back(st(0, 0, 0, NK, O_NEW));
    for (int i = 0; i < 8; i++) begin
      q.push_back(st(0, 0, 1, NK, O_NEW));
      q.push_back(st(0, 0, 0, NK, O_NEW));
    end
    q.push_back(st(0, 0, 1, 4'd7, O_ST));
    q.push_back(st(0, 0, 0, NK, O_NEW));
    q.push_back(st(0, 0, 0, NK, O_NEW));
    for (int i = 0; i < 9; i++) begin
      q.push_back(st(0, 0, 1, NK, O_NEW));
      q.push_back(st(0, 0, 0, NK, O_NEW));
    end
    q.push_back(st(0, 0, 1, 4'd8, O_ST));
    q.push_back(st(0, 0, 0, NK, O_NEW));
    q.push_back(st(0, 0, 0, NK, O_NEW));
    for (int i = 0; i < 9; i++) begin
      q.push_back(st(0, 0, 1, NK, O_NEW));
      q.push_back(st(0, 0, 0, NK, O_NEW));
    end
    q.push_back(st(0, 0, 1, NK, O_IDLE));
    q.push_back(st(0, 0, 0, 4'd6, O_ST));
    q.push_back(st(0, 0, 0, 4'd6, O_NEW));
    for (int i = 0; i < 9; i++) begin
      q.push_back(st(0, 0, 1, 4'd6, O_NEW));
      q.push_back(st(0, 0, 0, 4'd6, O_NEW));
    end
    q.push_back(st(0, 0, 1, 4'd6, O_IDLE));
    q.push_back(st(0, 0, 0, NK, O_IDLE));
    foreach (q[i]) begin
      drive(q[i]);
      n_checks++;
      if (outs() !== q[i].e)
        $display("FAIL timeout[%0d]: got %b expected %b",
                 i, outs(), q[i].e);
      else n_pass++;
    end
  endtask

  task automatic test_buttons();
    step_t q[$];
    q.push_back(st(0, 0, 0, 4'd9, O_ST));
    q.push_back(st(0, 0, 0, NK, O_NEW));
    q.push_back(st(0, 0, 0, NK, O_NEW));
    q.push_back(st(1, 1, 0, NK, O_SETA));
    q.push_back(st(0, 0, 0, NK, O_IDLE));
    for (int i = 0; i < 8; i++)
      q.push_back(st(1, (i == 1), 0, (i == 4) ? 4'd4 : NK, O_ALARM));
    q.push_back(st(0, 0, 0, NK, O_IDLE));
    q.push_back(st(0, 0, 0, 4'd2, O_ST));
    q.push_back(st(1, 1, 0, 4'd2, O_NEW));
    q.push_back(st(1, 1, 0, 4'd2, O_NEW));
    q.push_back(st(1, 0, 0, NK, O_NEW));
    q.push_back(st(1, 0, 0, NK, O_SETA));
    q.push_back(st(0, 0, 0, NK, O_IDLE));
    foreach (q[i]) begin
      drive(q[i]);
      n_checks++;
      if (outs() !== q[i].e)
        $display("FAIL buttons[%0d]: got %b expected %b",
                 i, outs(), q[i].e);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    drive(st(0, 0, 0, 4'd3, O_ST));
    drive(st(0, 0, 0, 4'd3, O_NEW));
    n_checks++;
    if (outs() !== O_NEW)
      $display("FAIL mid_waited: got %b expected %b", outs(), O_NEW);
    else n_pass++;
    bus.alarm_button = 1'b1;
    bus.time_button  = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (outs() !== O_IDLE)
      $display("FAIL mid_async: got %b expected %b", outs(), O_IDLE);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock);
      #1;
      n_checks++;
      if (outs() !== O_IDLE)
        $display("FAIL mid_held[%0d]: got %b expected %b",
                 i, outs(), O_IDLE);
      else n_pass++;
    end
    bus.alarm_button = 1'b0;
    bus.time_button  = 1'b0;
    bus.key          = NK;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(st(0, 0, 0, NK, O_IDLE));
      n_checks++;
      if (outs() !== O_IDLE)
        $display("FAIL mid_after[%0d]: got %b expected %b",
                 i, outs(), O_IDLE);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_key_hold();
    test_entry();
    test_timeout();
    test_buttons();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
